// File: rtl/merge_sort_indexed.sv
// rtl/merge_sort_indexed.sv - stable iterative merge sort returning original key positions
// One merge write per clock between ping-pong buffers A and B.
module merge_sort_indexed #(
    parameter int N  = 4,
    parameter int W  = 8,
    parameter int IW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          descending,
    input  logic [W-1:0]  data_in  [0:N-1],
    output logic [W-1:0]  data_out [0:N-1],
    output logic [IW-1:0] idx_out  [0:N-1],
    output logic          busy,
    output logic          done
);
    localparam int L  = $clog2(N);
    localparam int PW = (L > 1) ? $clog2(L) : 1;

    typedef enum logic {IDLE, MERGE} state_t;

    state_t        state, state_n;
    logic [W-1:0]  key_a [0:N-1];
    logic [W-1:0]  key_b [0:N-1];
    logic [IW-1:0] idx_a [0:N-1];
    logic [IW-1:0] idx_b [0:N-1];
    logic          desc_r;
    logic [PW-1:0] pass;
    logic [IW-1:0] lo, li, ri;
    logic [IW-1:0] w, l_pos, r_pos, wr_pos;
    logic [W-1:0]  lk, rk, sel_key;
    logic [IW-1:0] lx, rx, sel_idx;
    logic          left_ok, right_ok, take_left;
    logic          run_last, pass_last, final_last, accept;

    // Even passes read A and write B; odd passes the reverse.
    always_comb begin
        w         = IW'(1) << pass;
        l_pos     = lo + li;
        r_pos     = lo + w + ri;
        wr_pos    = lo + li + ri;
        lk        = pass[0] ? key_b[l_pos] : key_a[l_pos];
        lx        = pass[0] ? idx_b[l_pos] : idx_a[l_pos];
        rk        = pass[0] ? key_b[r_pos] : key_a[r_pos];
        rx        = pass[0] ? idx_b[r_pos] : idx_a[r_pos];
        left_ok   = li < w;
        right_ok  = ri < w;
        if (!right_ok)
            take_left = 1'b1;
        else if (!left_ok)
            take_left = 1'b0;
        else
            take_left = desc_r ? (lk >= rk) : (lk <= rk);
        sel_key    = take_left ? lk : rk;
        sel_idx    = take_left ? lx : rx;
        run_last   = ({1'b0, li} + {1'b0, ri} + (IW+1)'(1)) == {w, 1'b0};
        pass_last  = wr_pos == IW'(N - 1);
        final_last = pass_last && (pass == PW'(L - 1));
    end

    always_comb begin
        state_n = state;
        accept  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = MERGE;
                    accept  = 1'b1;
                end
            end
            MERGE: begin
                if (final_last)
                    state_n = IDLE;
            end
        endcase
    end

    assign busy = (state == MERGE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            done   <= 1'b0;
            desc_r <= 1'b0;
            pass   <= '0;
            lo     <= '0;
            li     <= '0;
            ri     <= '0;
            for (int i = 0; i < N; i++) begin
                data_out[i] <= '0;
                idx_out[i]  <= '0;
            end
        end else begin
            state <= state_n;
            done  <= (state == MERGE) && final_last;
            if (accept) begin
                desc_r <= descending;
                pass   <= '0;
                lo     <= '0;
                li     <= '0;
                ri     <= '0;
            end else if (state == MERGE) begin
                if (take_left)
                    li <= li + IW'(1);
                else
                    ri <= ri + IW'(1);
                if (run_last) begin
                    lo <= lo + (w << 1);
                    li <= '0;
                    ri <= '0;
                end
                if (pass_last) begin
                    pass <= pass + PW'(1);
                    lo   <= '0;
                end
                // Result is the destination buffer with this edge's write folded in.
                if (final_last) begin
                    for (int i = 0; i < N; i++) begin
                        data_out[i] <= (wr_pos == IW'(i)) ? sel_key : (pass[0] ? key_a[i] : key_b[i]);
                        idx_out[i]  <= (wr_pos == IW'(i)) ? sel_idx : (pass[0] ? idx_a[i] : idx_b[i]);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            for (int i = 0; i < N; i++) begin
                key_a[i] <= data_in[i];
                idx_a[i] <= IW'(i);
            end
        end else if (state == MERGE) begin
            if (pass[0]) begin
                key_a[wr_pos] <= sel_key;
                idx_a[wr_pos] <= sel_idx;
            end else begin
                key_b[wr_pos] <= sel_key;
                idx_b[wr_pos] <= sel_idx;
            end
        end
    end
endmodule

// File: doc/merge_sort_indexed.md
# merge_sort_indexed

Parametrised, stable, iterative merge-sort engine for the BWT datapath. Sorts N keys of W bits and also returns each sorted key's original position, which the BWT stage needs to rebuild rotation order. Supports ascending or descending order per job, with a start/busy/done handshake. Uses ping-pong internal buffers and performs one compare/write per clock.

## Interface
- N, default 4: number of keys; power of two, N >= 2.
- W, default 8: key width in bits.
- IW, default $clog2(N): index width (derived; do not override).
- L: number of merge passes, equal to $clog2(N) (derived).

- clk  in  1  rising-edge clock.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  job request; sampled only in IDLE.
- descending  in  1  sort order, captured with start: 0 = ascending, 1 = descending.
- data_in  in  W x [0:N-1]  unpacked key array; captured at the accepting edge.
- data_out  out  W x [0:N-1]  sorted keys.
- idx_out  out  IW x [0:N-1]  original position of each data_out entry.
- busy  out  1  high from the accepting edge until the completing edge.
- done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, MERGE.
- **IDLE.** When start = 1 at an edge:
  - Load buffer A with data_in[i] and index tag i.
  - Latch descending.
  - Set busy = 1, run width = 1, pass = 0, write pointer = 0.
  - Go to MERGE.
- **MERGE.** Each edge writes one element into the destination buffer, which alternates A->B, B->A per pass.
  - Merge adjacent runs [lo, lo+w) and [lo+w, lo+2w).
  - Left and right read pointers advance independently; an exhausted run yields to the other.
  - Compare rule (ascending): take left if left.key <= right.key.
  - Compare rule (descending): take left if left.key >= right.key.
  - Ties always take left, so the sort is stable in both modes.
  - After N writes the pass ends, the width doubles, and the buffers swap.
- **Completion.** On the edge that writes the last element of pass L-1:
  - data_out/idx_out are loaded from the final merge contents, written element included.
  - done = 1, busy = 0, FSM returns to IDLE.
- start while busy is ignored; no queuing.
- data_in and descending changes while busy have no effect.
- data_out/idx_out hold their value between completions; they change only on a completing edge.
- Reset, at any time including mid-sort:
  - FSM goes to IDLE; busy = 0, done = 0.
  - data_out and idx_out all zero.
  - The in-flight job is discarded.
  - Internal buffers need no reset.
- Keys are compared as unsigned W-bit values.

## Timing
- Start accepted at edge t0. Merge writes occupy edges t0+1 .. t0+N*L; the completing edge is t0+N*L.
- done is high for exactly the one cycle after t0+N*L and clears at the next edge.
- Latencies:
  - N = 4: 8 cycles.
  - N = 8: 24 cycles.
  - N = 16: 64 cycles.
- Back-to-back operation: start held high during the done cycle is accepted at the next edge. Throughput is one job per N*L+1 cycles.
- busy is high on cycles t0+1 .. t0+N*L, i.e. the cycles between the accepting edge and the completing edge.
- Reset deassertion: the first edge with rst = 0 may accept start.

## Test plan
1. **Basic ascending.** N=4, W=8, data_in "badc", ascending, start pulse.
   - data_out = "abcd", idx_out = {1,0,3,2}.
   - done pulses exactly 8 cycles after acceptance.
   - busy is high for 8 cycles.
2. **Stability and descending.** data_in {5,3,5,3}.
   - Ascending: data_out {3,3,5,5}, idx_out {1,3,0,2}.
   - Descending: data_out {5,5,3,3}, idx_out {0,2,1,3}.
3. **N=8 edge keys.** Keys {0xFF,0x00,0x80,0x7F,0x01,0xFE,0x00,0x80}, ascending.
   - data_out {00,00,01,7F,80,80,FE,FF}, idx_out {1,6,4,3,2,7,5,0}.
   - done exactly 24 cycles after acceptance.
4. **start while busy.** Pulse start again 3 cycles after acceptance with different data_in.
   - Result matches the first job only.
   - Exactly one done pulse.
5. **Reset mid-sort.** Assert rst 4 cycles into a job.
   - Immediately: busy = 0, done = 0, outputs zero.
   - No done follows.
   - A fresh job afterwards completes correctly.
6. **Back-to-back jobs.** Hold start high through the done cycle.
   - Second job accepted on the following edge.
   - Its done arrives 8 cycles after that (N=4).
   - The first result stays on data_out until then.
